ex_muldiv: RTL and testbench

//  Consumer end of the decoder's mul/div interface: accepts MULT/MULTU/DIV/DIVU as decoded

---
 rtl/muldiv_pkg.sv | 47 ++++
 rtl/radix2_div_step.sv | 36 +++
 rtl/ex_muldiv.sv | 164 ++++++++++++++++
 tb/tb_ex_muldiv.sv | 457 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// ----------------------------------------------------------------------------
// muldiv_pkg
// Shared definitions for the EX-stage multiply/divide unit:
//   - aluop encodings of the four HI/LO arithmetic instructions
//   - data width and number of restoring-divide iterations
//   - FSM state encoding
//   - small helpers for op classification and magnitude
// ----------------------------------------------------------------------------
package muldiv_pkg;

  // aluop values produced by the decoder for the HI/LO arithmetic group
  localparam logic [7:0] EXE_MULT_OP  = 8'b0001_1000;
  localparam logic [7:0] EXE_MULTU_OP = 8'b0001_1001;
  localparam logic [7:0] EXE_DIV_OP   = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP  = 8'b0001_1011;

  localparam int DATA_W    = 32;
  // One quotient bit per iteration, so this must track DATA_W
  localparam int DIV_ITERS = DATA_W;
  localparam int CNT_W     = $clog2(DIV_ITERS);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MUL      = 2'd1,
    ST_DIV_BUSY = 2'd2,
    ST_DONE     = 2'd3
  } state_t;

  function automatic logic op_is_mul_f(input logic [7:0] op);
    return (op == EXE_MULT_OP) || (op == EXE_MULTU_OP);
  endfunction

  function automatic logic op_is_div_f(input logic [7:0] op);
    return (op == EXE_DIV_OP) || (op == EXE_DIVU_OP);
  endfunction

  function automatic logic op_is_signed_f(input logic [7:0] op);
    return (op == EXE_MULT_OP) || (op == EXE_DIV_OP);
  endfunction

  // Two's-complement magnitude; 0x8000_0000 maps to itself, which is the
  // correct unsigned magnitude for the divider datapath
  function automatic logic [DATA_W-1:0] abs_f(input logic [DATA_W-1:0] v);
    return v[DATA_W-1] ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/radix2_div_step.sv
// ----------------------------------------------------------------------------
// radix2_div_step
// One combinational step of unsigned restoring division.
//   rem_i   partial remainder (always < dvs_i)
//   dvd_i   dividend bits not yet consumed, MSB first
//   dvs_i   divisor magnitude
//   rem_o   next partial remainder
//   dvd_o   dividend shifted left by one (LSB freed for the quotient bit)
//   qbit_o  quotient bit produced by this step
// ----------------------------------------------------------------------------
module radix2_div_step
  import muldiv_pkg::*;
(
  input  logic [DATA_W-1:0] rem_i,
  input  logic [DATA_W-1:0] dvd_i,
  input  logic [DATA_W-1:0] dvs_i,
  output logic [DATA_W-1:0] rem_o,
  output logic [DATA_W-1:0] dvd_o,
  output logic              qbit_o
);

  logic [DATA_W:0]   rem_shift;
  logic [DATA_W-1:0] diff;

  // The shifted remainder needs one extra bit for the compare, but when the
  // subtraction is taken the result is below the divisor, so a DATA_W-bit
  // difference is exact.
  always_comb begin
    rem_shift = {rem_i, dvd_i[DATA_W-1]};
    diff      = rem_shift[DATA_W-1:0] - dvs_i;
    qbit_o    = (rem_shift >= {1'b0, dvs_i});
    rem_o     = qbit_o ? diff : rem_shift[DATA_W-1:0];
    dvd_o     = {dvd_i[DATA_W-2:0], 1'b0};
  end

endmodule

// File: rtl/ex_muldiv.sv
// ----------------------------------------------------------------------------
// ex_muldiv
// EX-stage multi-cycle unit for MULT/MULTU/DIV/DIVU producing HI/LO.
// Multiply takes two cycles after accept, divide is radix-2 restoring
// (one quotient bit per cycle). The pipeline is held through stall_o while
// the operation runs; the result is presented for one cycle in DONE.
// Ports:
//   clk            clock, rising edge
//   rst            asynchronous reset, active low
//   start_i        EX holds a valid, non-annulled instruction
//   aluop_i        decoded aluop
//   reg1_i         multiplicand / dividend
//   reg2_i         multiplier / divisor
//   flush_i        abort any operation, no result
//   stall_o        hold IF..EX this cycle
//   result_valid_o one-cycle HI/LO write strobe
//   hi_o           mul high word / div remainder
//   lo_o           mul low word / div quotient
// ----------------------------------------------------------------------------
module ex_muldiv
  import muldiv_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [7:0]        aluop_i,
  input  logic [DATA_W-1:0] reg1_i,
  input  logic [DATA_W-1:0] reg2_i,
  input  logic              flush_i,
  output logic              stall_o,
  output logic              result_valid_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  state_t state, state_next;

  logic op_is_mul, op_is_div, op_signed, div_by_zero, accept;

  // dvd/dvs hold the multiply operands during MUL and the divide magnitudes
  // during DIV_BUSY; dvd also collects the quotient bits as it shifts out.
  logic [DATA_W-1:0] dvd, dvs, rem;
  logic [CNT_W-1:0]  cnt;
  logic              sgn_q, neg_quo, neg_rem;

  logic [DATA_W-1:0]   step_rem, step_dvd, quo_final;
  logic                step_qbit;
  logic [2*DATA_W-1:0] mul_a, mul_b, product;

  // Accept is gated by rst so stall_o stays low while reset is held
  always_comb begin
    op_is_mul   = op_is_mul_f(aluop_i);
    op_is_div   = op_is_div_f(aluop_i);
    op_signed   = op_is_signed_f(aluop_i);
    div_by_zero = (reg2_i == '0);
    accept      = rst && (state == ST_IDLE) && start_i &&
                  (op_is_mul || op_is_div) && !flush_i;
  end

  radix2_div_step u_step (
    .rem_i  (rem),
    .dvd_i  (dvd),
    .dvs_i  (dvs),
    .rem_o  (step_rem),
    .dvd_o  (step_dvd),
    .qbit_o (step_qbit)
  );

  // A 64x64 product truncated to 64 bits is correct for both signed and
  // unsigned once the operands are extended according to signedness.
  always_comb begin
    quo_final = step_dvd | {{(DATA_W-1){1'b0}}, step_qbit};
    mul_a     = {{DATA_W{sgn_q & dvd[DATA_W-1]}}, dvd};
    mul_b     = {{DATA_W{sgn_q & dvs[DATA_W-1]}}, dvs};
    product   = mul_a * mul_b;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_next;
  end

  // Next state and control outputs. stall_o drops as soon as a flush arrives
  // so the pipeline can redirect in the same cycle.
  always_comb begin
    state_next     = state;
    stall_o        = 1'b0;
    result_valid_o = 1'b0;
    case (state)
      ST_IDLE: begin
        stall_o = accept;
        if (accept) begin
          if (op_is_mul)        state_next = ST_MUL;
          else if (div_by_zero) state_next = ST_DONE;
          else                  state_next = ST_DIV_BUSY;
        end
      end
      ST_MUL: begin
        stall_o    = !flush_i;
        state_next = flush_i ? ST_IDLE : ST_DONE;
      end
      ST_DIV_BUSY: begin
        stall_o = !flush_i;
        if (flush_i)        state_next = ST_IDLE;
        else if (cnt == '0) state_next = ST_DONE;
      end
      ST_DONE: begin
        result_valid_o = !flush_i;
        state_next     = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Operand capture, divide iteration and HI/LO update. HI/LO are written
  // only on the edge that enters DONE, so they hold the last result otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dvd     <= '0;
      dvs     <= '0;
      rem     <= '0;
      cnt     <= '0;
      sgn_q   <= 1'b0;
      neg_quo <= 1'b0;
      neg_rem <= 1'b0;
      hi_o    <= '0;
      lo_o    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            dvd     <= (op_is_div && op_signed) ? abs_f(reg1_i) : reg1_i;
            dvs     <= (op_is_div && op_signed) ? abs_f(reg2_i) : reg2_i;
            rem     <= '0;
            cnt     <= CNT_W'(DIV_ITERS - 1);
            sgn_q   <= op_signed;
            neg_quo <= op_signed && (reg1_i[DATA_W-1] ^ reg2_i[DATA_W-1]);
            neg_rem <= op_signed && reg1_i[DATA_W-1];
            if (op_is_div && div_by_zero) begin
              hi_o <= reg1_i;
              lo_o <= '1;
            end
          end
        end
        ST_MUL: begin
          if (!flush_i) {hi_o, lo_o} <= product;
        end
        ST_DIV_BUSY: begin
          if (!flush_i) begin
            rem <= step_rem;
            dvd <= quo_final;
            cnt <= cnt - 1'b1;
            if (cnt == '0) begin
              hi_o <= neg_rem ? -step_rem  : step_rem;
              lo_o <= neg_quo ? -quo_final : quo_final;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// ----------------------------------------------------------------------------
// tb_ex_muldiv
// Self-checking bench for ex_muldiv. Expected HI/LO pairs are queued when an
// operation is issued and compared when result_valid_o pulses; each scenario
// task also checks stall/valid timing cycle by cycle.
// ----------------------------------------------------------------------------
module tb_ex_muldiv;
  import muldiv_pkg::*;

  logic        clk     = 1'b0;
  logic        rst     = 1'b1;
  logic        start_i = 1'b0;
  logic        flush_i = 1'b0;
  logic [7:0]  aluop_i = '0;
  logic [31:0] reg1_i  = '0;
  logic [31:0] reg2_i  = '0;
  logic        stall_o, result_valid_o;
  logic [31:0] hi_o, lo_o;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_exp;
  logic [31:0] last_hi = '0;
  logic [31:0] last_lo = '0;
  int          vectors     = 0;
  int          miscompares = 0;

  ex_muldiv dut (
    .clk            (clk),
    .rst            (rst),
    .start_i        (start_i),
    .aluop_i        (aluop_i),
    .reg1_i         (reg1_i),
    .reg2_i         (reg2_i),
    .flush_i        (flush_i),
    .stall_o        (stall_o),
    .result_valid_o (result_valid_o),
    .hi_o           (hi_o),
    .lo_o           (lo_o)
  );

  always #5 clk = ~clk;

  // Scoreboard: every result pulse must match the oldest queued expectation
  always @(negedge clk) begin
    if (rst === 1'b1 && result_valid_o === 1'b1) begin
      vectors++;
      if (sb_q.size() == 0) begin
        miscompares++;
        $display("[TB] FAIL unexpected_pulse: got hi=%h lo=%h, expected no result", hi_o, lo_o);
      end else begin
        mon_exp = sb_q.pop_front();
        last_hi = mon_exp.hi;
        last_lo = mon_exp.lo;
        if ({hi_o, lo_o} !== {mon_exp.hi, mon_exp.lo}) begin
          miscompares++;
          $display("[TB] FAIL result: got hi=%h lo=%h, expected hi=%h lo=%h",
                   hi_o, lo_o, mon_exp.hi, mon_exp.lo);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
    start_i = s;
    aluop_i = op;
    reg1_i  = a;
    reg2_i  = b;
  endtask

  task automatic push(input logic [31:0] h, input logic [31:0] l);
    sb_q.push_back(exp_t'({h, l}));
  endtask

  // Independent reference built on native SV arithmetic
  function automatic logic [63:0] model(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    p  = '0;
    case (op)
      EXE_MULT_OP:  begin q = sa * sb; p = q; end
      EXE_MULTU_OP: p = {32'd0, a} * {32'd0, b};
      EXE_DIV_OP: begin
        if (b == 0) p = {a, 32'hFFFF_FFFF};
        else begin q = sa / sb; r = sa % sb; p = {r[31:0], q[31:0]}; end
      end
      EXE_DIVU_OP: begin
        if (b == 0) p = {a, 32'hFFFF_FFFF};
        else p = {a % b, a / b};
      end
      default: p = '0;
    endcase
    return p;
  endfunction

  task automatic test_reset();
    #2 rst = 1'b0;
    drive(1'b1, EXE_MULT_OP, 32'd7, 32'd9);
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({stall_o, result_valid_o} !== 2'b00) begin
      miscompares++;
      $display("[TB] FAIL reset_ctrl: got stall/valid=%b, expected 00", {stall_o, result_valid_o});
    end
    vectors++;
    if ({hi_o, lo_o} !== 64'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_data: got %h, expected 0", {hi_o, lo_o});
    end
    drive(1'b0, '0, '0, '0);
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_mult();
    drive(1'b1, EXE_MULT_OP, 32'hFFFF_FFFE, 32'd3);
    push(32'hFFFF_FFFF, 32'hFFFF_FFFA);
    @(negedge clk);
    vectors++;
    if (stall_o !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL mult_T: got stall=%b, expected 1", stall_o);
    end
    tick();
    drive(1'b0, '0, '0, '0);
    @(negedge clk);
    vectors++;
    if ({stall_o, result_valid_o} !== 2'b10) begin
      miscompares++;
      $display("[TB] FAIL mult_T1: got stall/valid=%b, expected 10", {stall_o, result_valid_o});
    end
    tick();
    @(negedge clk);
    vectors++;
    if ({stall_o, result_valid_o} !== 2'b01) begin
      miscompares++;
      $display("[TB] FAIL mult_T2: got stall/valid=%b, expected 01", {stall_o, result_valid_o});
    end
    tick();
  endtask

  task automatic test_divu();
    drive(1'b1, EXE_DIVU_OP, 32'd100, 32'd7);
    push(32'd2, 32'd14);
    for (int i = 0; i < 33; i++) begin
      @(negedge clk);
      vectors++;
      if ({stall_o, result_valid_o} !== 2'b10) begin
        miscompares++;
        $display("[TB] FAIL divu_busy T+%0d: got stall/valid=%b, expected 10", i, {stall_o, result_valid_o});
      end
      tick();
      if (i == 0) drive(1'b0, '0, '0, '0);
    end
    @(negedge clk);
    vectors++;
    if ({stall_o, result_valid_o} !== 2'b01) begin
      miscompares++;
      $display("[TB] FAIL divu_done: got stall/valid=%b, expected 01", {stall_o, result_valid_o});
    end
    tick();
    @(negedge clk);
    vectors++;
    if ({stall_o, result_valid_o} !== 2'b00) begin
      miscompares++;
      $display("[TB] FAIL divu_idle: got stall/valid=%b, expected 00", {stall_o, result_valid_o});
    end
    tick();
  endtask

  task automatic test_div_signed();
    logic [31:0] ta[2];
    logic [31:0] tb[2];
    logic [31:0] eh[2];
    logic [31:0] el[2];
    int lat;
    ta = '{32'hFFFF_FFF9, 32'h8000_0000};
    tb = '{32'd2,         32'hFFFF_FFFF};
    eh = '{32'hFFFF_FFFF, 32'h0};
    el = '{32'hFFFF_FFFD, 32'h8000_0000};
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, EXE_DIV_OP, ta[k], tb[k]);
      push(eh[k], el[k]);
      lat = -1;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (result_valid_o === 1'b1) begin lat = i; break; end
        tick();
        if (i == 0) drive(1'b0, '0, '0, '0);
      end
      vectors++;
      if (lat != 33) begin
        miscompares++;
        $display("[TB] FAIL div_signed_latency[%0d]: got %0d, expected 33", k, lat);
      end
      tick();
    end
  endtask

  task automatic test_div_zero();
    logic [7:0]  zop[3];
    logic [31:0] za[3];
    zop = '{EXE_DIV_OP, EXE_DIV_OP, EXE_DIVU_OP};
    za  = '{32'd5, 32'hFFFF_FFF7, 32'hFFFF_FFF0};
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, zop[k], za[k], 32'd0);
      push(za[k], 32'hFFFF_FFFF);
      @(negedge clk);
      vectors++;
      if (stall_o !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL divz_T[%0d]: got stall=%b, expected 1", k, stall_o);
      end
      tick();
      drive(1'b0, '0, '0, '0);
      @(negedge clk);
      vectors++;
      if ({stall_o, result_valid_o} !== 2'b01) begin
        miscompares++;
        $display("[TB] FAIL divz_T1[%0d]: got stall/valid=%b, expected 01", k, {stall_o, result_valid_o});
      end
      tick();
    end
  endtask

  task automatic test_flush();
    int lat;
    drive(1'b1, EXE_DIVU_OP, 32'd1000, 32'd3);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      tick();
      if (i == 0) drive(1'b0, '0, '0, '0);
    end
    flush_i = 1'b1;
    @(negedge clk);
    vectors++;
    if ({stall_o, result_valid_o} !== 2'b00) begin
      miscompares++;
      $display("[TB] FAIL flush_cycle: got stall/valid=%b, expected 00", {stall_o, result_valid_o});
    end
    tick();
    flush_i = 1'b0;
    @(negedge clk);
    vectors++;
    if ({stall_o, result_valid_o} !== 2'b00) begin
      miscompares++;
      $display("[TB] FAIL flush_idle: got stall/valid=%b, expected 00", {stall_o, result_valid_o});
    end
    vectors++;
    if ({hi_o, lo_o} !== {last_hi, last_lo}) begin
      miscompares++;
      $display("[TB] FAIL flush_hold: got %h, expected %h", {hi_o, lo_o}, {last_hi, last_lo});
    end
    tick();
    drive(1'b1, EXE_DIVU_OP, 32'd9, 32'd3);
    push(32'd0, 32'd3);
    lat = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (result_valid_o === 1'b1) begin lat = i; break; end
      tick();
      if (i == 0) drive(1'b0, '0, '0, '0);
    end
    vectors++;
    if (lat != 33) begin
      miscompares++;
      $display("[TB] FAIL flush_restart_latency: got %0d, expected 33", lat);
    end
    tick();
    // flush coinciding with a would-be accept
    drive(1'b1, EXE_MULT_OP, 32'd5, 32'd6);
    flush_i = 1'b1;
    @(negedge clk);
    vectors++;
    if (stall_o !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL flush_accept: got stall=%b, expected 0", stall_o);
    end
    tick();
    drive(1'b0, '0, '0, '0);
    flush_i = 1'b0;
    @(negedge clk);
    vectors++;
    if ({stall_o, result_valid_o} !== 2'b00) begin
      miscompares++;
      $display("[TB] FAIL flush_accept_next: got stall/valid=%b, expected 00", {stall_o, result_valid_o});
    end
    tick();
    // a non mul/div aluop is ignored
    drive(1'b1, 8'h25, 32'd5, 32'd6);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      vectors++;
      if ({stall_o, result_valid_o} !== 2'b00) begin
        miscompares++;
        $display("[TB] FAIL other_op[%0d]: got stall/valid=%b, expected 00", i, {stall_o, result_valid_o});
      end
      tick();
    end
    drive(1'b0, '0, '0, '0);
    tick();
  endtask

  task automatic test_reset_mid();
    drive(1'b1, EXE_DIV_OP, 32'd100, 32'd7);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tick();
      if (i == 0) drive(1'b0, '0, '0, '0);
    end
    rst = 1'b0;
    #1;
    vectors++;
    if ({stall_o, result_valid_o} !== 2'b00) begin
      miscompares++;
      $display("[TB] FAIL rstmid_ctrl: got stall/valid=%b, expected 00", {stall_o, result_valid_o});
    end
    vectors++;
    if ({hi_o, lo_o} !== 64'd0) begin
      miscompares++;
      $display("[TB] FAIL rstmid_data: got %h, expected 0", {hi_o, lo_o});
    end
    last_hi = '0;
    last_lo = '0;
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_back_to_back();
    // start_i stays high through DONE for the owning MULTU
    drive(1'b1, EXE_MULTU_OP, 32'h0001_0000, 32'h0001_0000);
    push(32'd1, 32'd0);
    @(negedge clk);
    vectors++;
    if (stall_o !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL hold_T: got stall=%b, expected 1", stall_o);
    end
    tick();
    @(negedge clk);
    vectors++;
    if ({stall_o, result_valid_o} !== 2'b10) begin
      miscompares++;
      $display("[TB] FAIL hold_T1: got stall/valid=%b, expected 10", {stall_o, result_valid_o});
    end
    tick();
    @(negedge clk);
    vectors++;
    if ({stall_o, result_valid_o} !== 2'b01) begin
      miscompares++;
      $display("[TB] FAIL hold_done: got stall/valid=%b, expected 01", {stall_o, result_valid_o});
    end
    tick();
    // next instruction arrives the cycle after DONE
    drive(1'b1, EXE_MULTU_OP, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    push(32'hFFFF_FFFE, 32'h0000_0001);
    @(negedge clk);
    vectors++;
    if (stall_o !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL b2b_accept: got stall=%b, expected 1", stall_o);
    end
    tick();
    drive(1'b0, '0, '0, '0);
    @(negedge clk);
    vectors++;
    if ({stall_o, result_valid_o} !== 2'b10) begin
      miscompares++;
      $display("[TB] FAIL b2b_T1: got stall/valid=%b, expected 10", {stall_o, result_valid_o});
    end
    tick();
    @(negedge clk);
    vectors++;
    if ({stall_o, result_valid_o} !== 2'b01) begin
      miscompares++;
      $display("[TB] FAIL b2b_done: got stall/valid=%b, expected 01", {stall_o, result_valid_o});
    end
    tick();
  endtask

  task automatic test_random_ops();
    logic [7:0]  ops[4];
    logic [7:0]  op;
    logic [31:0] a, b;
    logic [63:0] e;
    int          lat, exp_lat;
    ops = '{EXE_MULT_OP, EXE_MULTU_OP, EXE_DIV_OP, EXE_DIVU_OP};
    for (int k = 0; k < 10; k++) begin
      op = ops[k % 4];
      a  = $urandom;
      b  = (k < 4) ? $urandom : 32'($urandom_range(0, 40));
      if (k == 6) b = -b;
      if (k == 9) b = 32'd0;
      e = model(op, a, b);
      if (op_is_mul_f(op))  exp_lat = 2;
      else if (b == 32'd0)  exp_lat = 1;
      else                  exp_lat = 33;
      push(e[63:32], e[31:0]);
      drive(1'b1, op, a, b);
      lat = -1;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (result_valid_o === 1'b1) begin lat = i; break; end
        tick();
        if (i == 0) drive(1'b0, '0, '0, '0);
      end
      vectors++;
      if (lat != exp_lat) begin
        miscompares++;
        $display("[TB] FAIL rand_latency[%0d] op=%h a=%h b=%h: got %0d, expected %0d", k, op, a, b, lat, exp_lat);
      end
      tick();
      drive(1'b0, '0, '0, '0);
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_divu();
    test_div_signed();
    test_div_zero();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    test_random_ops();
    repeat (2) tick();
    vectors++;
    if (sb_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

endmodule
